// File: rtl/alu_pkg.sv
// Shared definitions for the calculator ALU and its sequencing controller:
// data width, opcode encodings and controller FSM states.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD     = 3'd0;
  localparam logic [OP_W-1:0] OP_AND     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd2;
  localparam logic [OP_W-1:0] OP_LOAD_A  = 3'd3;
  localparam logic [OP_W-1:0] OP_M_PLUS  = 3'd4;
  localparam logic [OP_W-1:0] OP_M_MINUS = 3'd5;
  localparam logic [OP_W-1:0] OP_MR      = 3'd6;
  localparam logic [OP_W-1:0] OP_MC      = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit calculator ALU: ADD (mod 256), AND, XOR.
// Opcodes outside that set produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: accepts one command, executes it against ACC/MEM
// (via the ALU for ADD/AND/XOR), returns the result. Optional flags: ALU_SEQ_CTRL_FLAGS_EN.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_operand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_acc,
  output logic [DATA_W-1:0] rsp_mem,
  output logic              rsp_zero,
  output logic [CNT_W-1:0]  op_count
`ifdef ALU_SEQ_CTRL_FLAGS_EN
  ,
  output logic              rsp_carry,
  output logic              rsp_borrow
`endif
);

  state_t              state_reg, state_next;
  logic [OP_W-1:0]     op_reg;
  logic [DATA_W-1:0]   operand_reg;
  logic [DATA_W-1:0]   acc_reg, acc_next;
  logic [DATA_W-1:0]   mem_reg, mem_next;
  logic [DATA_W-1:0]   alu_y;

  alu u_alu (
    .a  (acc_reg),
    .b  (operand_reg),
    .op (op_reg),
    .y  (alu_y)
  );

  // Both handshake outputs decode only the state register.
  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next = acc_reg;
    mem_next = mem_reg;
    case (op_reg)
      OP_ADD, OP_AND, OP_XOR: acc_next = alu_y;
      OP_LOAD_A:              acc_next = operand_reg;
      OP_M_PLUS:              mem_next = mem_reg + acc_reg;
      OP_M_MINUS:             mem_next = mem_reg - acc_reg;
      OP_MR:                  acc_next = mem_reg;
      OP_MC:                  mem_next = '0;
      default:                ;
    endcase
  end

`ifdef ALU_SEQ_CTRL_FLAGS_EN
  logic carry_next, borrow_next;

  // a + b overflows 8 bits exactly when a > 255 - b, i.e. a > ~b.
  always_comb begin
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    case (op_reg)
      OP_ADD:     carry_next  = (acc_reg > ~operand_reg);
      OP_M_PLUS:  carry_next  = (mem_reg > ~acc_reg);
      OP_M_MINUS: borrow_next = (mem_reg < acc_reg);
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_carry  <= 1'b0;
      rsp_borrow <= 1'b0;
    end else if (state_reg == EXEC) begin
      rsp_carry  <= carry_next;
      rsp_borrow <= borrow_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op_reg      <= OP_ADD;
      operand_reg <= '0;
      acc_reg     <= '0;
      mem_reg     <= '0;
      rsp_acc     <= '0;
      rsp_mem     <= '0;
      rsp_zero    <= 1'b1;
      op_count    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cmd_valid) begin
        op_reg      <= cmd_op;
        operand_reg <= cmd_operand;
      end
      // Response fields are captured once here and hold through RESP and beyond.
      if (state_reg == EXEC) begin
        acc_reg  <= acc_next;
        mem_reg  <= mem_next;
        rsp_acc  <= acc_next;
        rsp_mem  <= mem_next;
        rsp_zero <= (acc_next == '0);
      end
      if (state_reg == RESP && rsp_ready)
        op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, backpressure and
// mid-operation reset sequences, then random commands against a reference model.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [7:0]        cmd_operand;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_acc;
  logic [7:0]        rsp_mem;
  logic              rsp_zero;
  logic [CNT_W-1:0]  op_count;
`ifdef ALU_SEQ_CTRL_FLAGS_EN
  logic              rsp_carry;
  logic              rsp_borrow;
`endif

  alu_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_acc     (rsp_acc),
    .rsp_mem     (rsp_mem),
    .rsp_zero    (rsp_zero),
    .op_count    (op_count)
`ifdef ALU_SEQ_CTRL_FLAGS_EN
    ,
    .rsp_carry   (rsp_carry),
    .rsp_borrow  (rsp_borrow)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_acc, m_mem;
  bit          m_carry, m_borrow;
  logic [15:0] m_count;

  typedef struct {
    logic [2:0] op;
    logic [7:0] opnd;
    logic [7:0] acc;
    logic [7:0] mem;
    logic       zero;
    logic       carry;
    logic       borrow;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_mem = 0; m_carry = 0; m_borrow = 0; m_count = '0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [7:0] opnd);
    int b;
    b = int'(opnd);
    m_carry  = 0;
    m_borrow = 0;
    case (op)
      3'd0: begin m_carry = (m_acc + b) > 255; m_acc = (m_acc + b) % 256; end
      3'd1: m_acc = m_acc & b;
      3'd2: m_acc = m_acc ^ b;
      3'd3: m_acc = b;
      3'd4: begin m_carry = (m_mem + m_acc) > 255; m_mem = (m_mem + m_acc) % 256; end
      3'd5: begin m_borrow = m_mem < m_acc; m_mem = (m_mem - m_acc + 256) % 256; end
      3'd6: m_acc = m_mem;
      default: m_mem = 0;
    endcase
  endtask

  task automatic check_rsp_vs_model(input string tag);
    check({tag, "_acc"},  rsp_acc,  m_acc[7:0]);
    check({tag, "_mem"},  rsp_mem,  m_mem[7:0]);
    check({tag, "_zero"}, rsp_zero, (m_acc == 0));
`ifdef ALU_SEQ_CTRL_FLAGS_EN
    check({tag, "_carry"},  rsp_carry,  m_carry);
    check({tag, "_borrow"}, rsp_borrow, m_borrow);
`endif
  endtask

  // One full command with rsp_ready high; checks latency, response and counter.
  task automatic send(input logic [2:0] op, input logic [7:0] opnd);
    int n;
    @(negedge clk);
    rsp_ready   = 1'b1;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = opnd;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_step(op, opnd);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("rsp_latency", n, 2);
    check_rsp_vs_model("rsp");
    check("busy_cmd_ready", cmd_ready, 1'b0);
    check("count_before_hs", op_count, m_count);
    @(negedge clk);
    m_count++;
    check("count_after_hs", op_count, m_count);
    check("rsp_valid_drop", rsp_valid, 1'b0);
    $display("cmd op=%0d opnd=%02h -> acc=%02h mem=%02h zero=%0b count=%0d",
             op, opnd, rsp_acc, rsp_mem, rsp_zero, op_count);
  endtask

  initial begin
    tbl[0]  = '{3'd3, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'd0, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'd3, 8'hF0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'd0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{3'd3, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'd4, 8'h00, 8'h0A, 8'h0A, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'd3, 8'h0F, 8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3'd5, 8'h00, 8'h0F, 8'hFB, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{3'd6, 8'h00, 8'hFB, 8'hFB, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd7, 8'h00, 8'hFB, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3'd3, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'd2, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{3'd3, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3'd1, 8'hFF, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_operand = '0; rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_acc",   rsp_acc,   8'h00);
    check("rst_rsp_mem",   rsp_mem,   8'h00);
    check("rst_rsp_zero",  rsp_zero,  1'b1);
    check("rst_op_count",  op_count,  16'h0);
`ifdef ALU_SEQ_CTRL_FLAGS_EN
    check("rst_carry",  rsp_carry,  1'b0);
    check("rst_borrow", rsp_borrow, 1'b0);
`endif
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].op, tbl[i].opnd);
      check($sformatf("tbl%0d_acc", i),  rsp_acc,  tbl[i].acc);
      check($sformatf("tbl%0d_mem", i),  rsp_mem,  tbl[i].mem);
      check($sformatf("tbl%0d_zero", i), rsp_zero, tbl[i].zero);
`ifdef ALU_SEQ_CTRL_FLAGS_EN
      check($sformatf("tbl%0d_carry", i),  rsp_carry,  tbl[i].carry);
      check($sformatf("tbl%0d_borrow", i), rsp_borrow, tbl[i].borrow);
`endif
      if (i == 1) check("tbl_op_count_2", op_count, 16'd2);
    end

    // Backpressure: response held 5 cycles while a second command waits
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = OP_LOAD_A; cmd_operand = 8'h77;
    @(posedge clk);
    model_step(OP_LOAD_A, 8'h77);
    @(negedge clk);
    cmd_op = OP_ADD; cmd_operand = 8'h01;
    @(negedge clk);
    check("bp_rsp_valid", rsp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", k), rsp_valid, 1'b1);
      check($sformatf("bp_hold%0d_acc", k),   rsp_acc,   8'h77);
      check($sformatf("bp_hold%0d_ready", k), cmd_ready, 1'b0);
      check($sformatf("bp_hold%0d_count", k), op_count,  m_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    m_count++;
    check("bp_hs_count", op_count, m_count);
    check("bp_hs_cmd_ready", cmd_ready, 1'b1);
    check("bp_hs_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk);
    model_step(OP_ADD, 8'h01);
    @(negedge clk);
    check("bp_second_accepted", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", rsp_valid, 1'b1);
    check_rsp_vs_model("bp_second");
    check("bp_second_acc", rsp_acc, 8'h78);
    @(negedge clk);
    m_count++;
    check("bp_second_count", op_count, m_count);
    $display("backpressure: held acc=77, second acc=%02h count=%0d", rsp_acc, op_count);

    // Reset asserted while an ADD is in EXEC
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_operand = 8'h11;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_acc",       rsp_acc,   8'h00);
    check("mid_rst_mem",       rsp_mem,   8'h00);
    check("mid_rst_zero",      rsp_zero,  1'b1);
    check("mid_rst_count",     op_count,  16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(OP_ADD, 8'h04);
    check("post_rst_add", rsp_acc, 8'h04);
    send(OP_M_PLUS, 8'h00);
    check("post_rst_mplus", rsp_mem, 8'h04);
    $display("mid-exec reset: post acc=%02h mem=%02h", rsp_acc, rsp_mem);

    // Random commands against the model, with idle gaps
    for (int r = 0; r < 150; r++) begin
      logic [2:0] op;
      logic [7:0] opnd;
      op   = 3'($urandom_range(0, 7));
      opnd = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op, opnd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
